// File: rtl/lfa_sub_pipe.sv
// lfa_sub_pipe: pipelined, valid/ready handshaked Ladner-Fischer subtractor.
// Computes a - b as a + ~b + 1. The carry-in of 1 is folded into the bit-0
// generate term. Every prefix level is a register stage, so the pipeline has
// DEPTH+1 stages (S0 = preprocess, S1..SDEPTH = prefix levels).
// Optional feature: define LFA_SUB_OVF_EN to carry the operand sign bits
// down the pipe and add the signed-overflow output ovf.
module lfa_sub_pipe #(
    parameter  int WIDTH = 16,
    localparam int DEPTH = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef LFA_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Per-stage state: valid bit, p0 (half-sum) carried to the end, group generate/propagate
    logic [DEPTH:0]   valid_r;
    logic [WIDTH-1:0] p0_r [0:DEPTH];
    logic [WIDTH-1:0] g_r  [0:DEPTH];
    logic [WIDTH-1:0] p_r  [0:DEPTH-1];
    logic [DEPTH:0]   ready_s;
    logic [WIDTH-1:0] nb_s;
    logic [WIDTH-1:0] p_in_s;
    logic [WIDTH-1:0] g_in_s;
    logic [WIDTH-1:0] diff_raw_s;
`ifdef LFA_SUB_OVF_EN
    logic [DEPTH:0]   sa_r;
    logic [DEPTH:0]   sb_r;
`endif

    // A stage can load when it is empty or everything below it will move.
    // Written in closed form to avoid a bit-serial combinational chain on one vector.
    for (genvar k = 0; k <= DEPTH; k++) begin : g_rdy
        assign ready_s[k] = out_ready | ~(&valid_r[DEPTH:k]);
    end

    // Handshakes are refused while reset is held
    assign in_ready = ready_s[0] & ~rst;

    // Preprocess: invert b, build half-sum and generate; bit 0 absorbs the carry-in of 1
    always_comb begin
        nb_s      = ~b;
        p_in_s    = a ^ nb_s;
        g_in_s    = a & nb_s;
        g_in_s[0] = a[0] | nb_s[0];
    end

    // Stage S0 register: preprocess results and the operand sign bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r[0] <= 1'b0;
            p0_r[0]    <= '0;
            g_r[0]     <= '0;
            p_r[0]     <= '0;
`ifdef LFA_SUB_OVF_EN
            sa_r[0]    <= 1'b0;
            sb_r[0]    <= 1'b0;
`endif
        end else if (ready_s[0]) begin
            valid_r[0] <= in_valid;
            p0_r[0]    <= p_in_s;
            g_r[0]     <= g_in_s;
            p_r[0]     <= p_in_s;
`ifdef LFA_SUB_OVF_EN
            sa_r[0]    <= a[WIDTH-1];
            sb_r[0]    <= b[WIDTH-1];
`endif
        end
    end

    // Prefix levels: in each 2^j group the upper half combines with the top bit of the lower half
    for (genvar j = 1; j <= DEPTH; j++) begin : g_lvl
        localparam int GRP  = 32'sd1 << j;
        localparam int HALF = GRP / 32'sd2;
        logic [WIDTH-1:0] g_nxt_s;

        for (genvar i = 0; i < WIDTH; i++) begin : g_gbit
            localparam int LO = (i / GRP) * GRP + HALF - 32'sd1;
            if ((i % GRP) >= HALF) begin : g_cell
                assign g_nxt_s[i] = g_r[j-1][i] | (p_r[j-1][i] & g_r[j-1][LO]);
            end else begin : g_pass
                assign g_nxt_s[i] = g_r[j-1][i];
            end
        end

        // Stage Sj register: combined generate, p0 passthrough, sign bits
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_r[j] <= 1'b0;
                p0_r[j]    <= '0;
                g_r[j]     <= '0;
`ifdef LFA_SUB_OVF_EN
                sa_r[j]    <= 1'b0;
                sb_r[j]    <= 1'b0;
`endif
            end else if (ready_s[j]) begin
                valid_r[j] <= valid_r[j-1];
                p0_r[j]    <= p0_r[j-1];
                g_r[j]     <= g_nxt_s;
`ifdef LFA_SUB_OVF_EN
                sa_r[j]    <= sa_r[j-1];
                sb_r[j]    <= sb_r[j-1];
`endif
            end
        end

        // Group propagate is only needed by later levels, so the last level has none
        if (j < DEPTH) begin : g_plvl
            logic [WIDTH-1:0] p_nxt_s;
            for (genvar i = 0; i < WIDTH; i++) begin : g_pbit
                localparam int LO = (i / GRP) * GRP + HALF - 32'sd1;
                if ((i % GRP) >= HALF) begin : g_cell
                    assign p_nxt_s[i] = p_r[j-1][i] & p_r[j-1][LO];
                end else begin : g_pass
                    assign p_nxt_s[i] = p_r[j-1][i];
                end
            end

            // Stage Sj propagate register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p_r[j] <= '0;
                end else if (ready_s[j]) begin
                    p_r[j] <= p_nxt_s;
                end
            end
        end
    end

    // Final sum from the last stage; bit i uses the carry out of bit i-1
    always_comb begin
        diff_raw_s              = '0;
        diff_raw_s[0]           = ~p0_r[DEPTH][0];
        diff_raw_s[WIDTH-1:1]   = p0_r[DEPTH][WIDTH-1:1] ^ g_r[DEPTH][WIDTH-2:0];
    end

    // Outputs are forced to zero when no result is held, so reset shows zeros
    always_comb begin
        out_valid = valid_r[DEPTH];
        diff      = '0;
        borrow    = 1'b0;
`ifdef LFA_SUB_OVF_EN
        ovf       = 1'b0;
`endif
        if (valid_r[DEPTH]) begin
            diff   = diff_raw_s;
            borrow = ~g_r[DEPTH][WIDTH-1];
`ifdef LFA_SUB_OVF_EN
            ovf    = (sa_r[DEPTH] ^ sb_r[DEPTH]) & (diff_raw_s[WIDTH-1] ^ sa_r[DEPTH]);
`endif
        end else begin
            diff   = '0;
            borrow = 1'b0;
`ifdef LFA_SUB_OVF_EN
            ovf    = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_lfa_sub_pipe.sv
// Directed self-checking bench for lfa_sub_pipe (WIDTH = 16, five stages).
module tb_lfa_sub_pipe;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow;
`ifdef LFA_SUB_OVF_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic        br;
        logic        ov;
    } vec_t;

    vec_t vecs [8];

    lfa_sub_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
`ifdef LFA_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One isolated transaction: checks accept, latency, result and single-cycle output
    task automatic run_single(input vec_t v);
        int lat;
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        #1;
        chk({v.name, " in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        a        = 16'h5A5A;
        b        = 16'hA5A5;
        lat      = 0;
        while (!out_valid && lat < 12) begin
            tick();
            lat++;
        end
        chk({v.name, " latency"}, 32'(lat), 32'(DEPTH));
        chk({v.name, " diff"}, 32'(diff), 32'(v.d));
        chk({v.name, " borrow"}, 32'(borrow), 32'(v.br));
`ifdef LFA_SUB_OVF_EN
        chk({v.name, " ovf"}, 32'(ovf), 32'(v.ov));
`endif
        tick();
        chk({v.name, " one cycle"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int          idx;
        int          first_c;
        int          acc;
        int          seen;
        logic [15:0] e;

        vecs[0] = '{"sub_1234_0034", 16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0};
        vecs[1] = '{"sub_0_1",       16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{"sub_equal",     16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{"sub_8000_1",    16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
        vecs[4] = '{"sub_7fff_ffff", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
        vecs[5] = '{"sub_5_3",       16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
        vecs[6] = '{"sub_ffff_0",    16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
        vecs[7] = '{"sub_0_ffff",    16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 16'h0000;
        b         = 16'h0000;
        tick();
        tick();
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset diff", 32'(diff), 32'd0);
        chk("reset borrow", 32'(borrow), 32'd0);
`ifdef LFA_SUB_OVF_EN
        chk("reset ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Table-driven isolated transactions
        for (int i = 0; i < 8; i++) begin
            run_single(vecs[i]);
        end

        // Streaming: pairs (i, 2i), expecting -i back to back
        idx     = 0;
        first_c = -1;
        for (int c = 0; c < 16; c++) begin
            if (out_valid) begin
                if (idx < 5) begin
                    e = 16'hFFFF - 16'(idx);
                    chk("stream diff", 32'(diff), 32'(e));
                    chk("stream borrow", 32'(borrow), 32'd1);
                    if (idx == 0) first_c = c;
                    chk("stream consecutive", 32'(c - first_c), 32'(idx));
                end else begin
                    chk("stream extra result", 32'(idx), 32'd4);
                end
                idx++;
            end
            if (c < 5) begin
                in_valid = 1'b1;
                a        = 16'(c + 1);
                b        = 16'(2 * (c + 1));
                #1;
                chk("stream in_ready", 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        chk("stream count", 32'(idx), 32'd5);
        chk("stream first latency", 32'(first_c), 32'(DEPTH + 1));

        // Backpressure: fill with out_ready low, then drain
        out_ready = 1'b0;
        acc       = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            a        = 16'h0100 + 16'(acc);
            b        = 16'h0000;
            #1;
            if (in_ready) acc++;
            tick();
        end
        chk("bp accepts", 32'(acc), 32'd5);
        chk("bp in_ready low", 32'(in_ready), 32'd0);
        chk("bp out_valid", 32'(out_valid), 32'd1);
        chk("bp diff head", 32'(diff), 32'h0100);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("bp stall valid", 32'(out_valid), 32'd1);
            chk("bp stall diff", 32'(diff), 32'h0100);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp in_ready rise", 32'(in_ready), 32'd1);
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) begin
                if (idx < 5) begin
                    chk("bp drain diff", 32'(diff), 32'h0100 + 32'(idx));
                    chk("bp drain order", 32'(c), 32'(idx));
                end else begin
                    chk("bp drain extra", 32'(idx), 32'd4);
                end
                idx++;
            end
            tick();
        end
        chk("bp drain count", 32'(idx), 32'd5);

        // Reset with three transactions in flight, head at the output
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            a        = 16'h0010 + 16'(c);
            b        = 16'h0001;
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        chk("pre-reset valid", 32'(out_valid), 32'd1);
        chk("pre-reset diff", 32'(diff), 32'h000F);
        rst = 1'b1;
        #1;
        chk("mid reset out_valid", 32'(out_valid), 32'd0);
        chk("mid reset diff", 32'(diff), 32'd0);
        chk("mid reset borrow", 32'(borrow), 32'd0);
`ifdef LFA_SUB_OVF_EN
        chk("mid reset ovf", 32'(ovf), 32'd0);
`endif
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = 16'h0001;
        b         = 16'h0002;
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        seen     = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("post-reset stale outputs", 32'(seen), 32'd0);
        run_single(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfa_sub_pipe.md
# lfa_sub_pipe

Pipelined, handshaked Ladner-Fischer subtractor computing A − B as the inverse operation of the team's combinational prefix adder. It forms two's-complement subtraction as A + ~B + 1 and registers every prefix level. A valid/ready stream interface sits on both sides. It serves datapaths that need high-frequency unsigned/signed difference and borrow, for example compare/decrement paths.

## Interface
- WIDTH, 16, operand width in bits; legal range ≥ 2, power of two not required.
- DEPTH, $clog2(WIDTH), number of prefix levels; derived and must not be overridden.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts the operand pair this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result this cycle.
- diff  output  WIDTH  (a − b) mod 2^WIDTH.
- borrow  output  1  1 when a < b (unsigned); equals the inverted carry-out.
- ovf  output  1  signed overflow; present only with LFA_SUB_OVF_EN.

## Operation
- Preprocess, at stage 0:
  - nb = ~b.
  - p0[i] = a[i] ^ nb[i].
  - g0[i] = a[i] & nb[i] for i ≥ 1.
  - g0[0] = a[0] | nb[0], which absorbs the carry-in of 1.
  - Registers hold p0, g0 and a valid bit.
- Prefix levels j = 1..DEPTH use Ladner-Fischer sparsity.
  - Within each 2^j group, the upper half of the bits combine with the top bit of the lower half:
    - g' = g_hi | (p_hi & g_lo)
    - p' = p_hi & p_lo
  - Lower-half bits pass through unchanged.
  - Indices ≥ WIDTH are dropped.
  - Each level is a register stage carrying p0 alongside, plus a valid bit.
- Output, combinational from the last stage:
  - diff[0] = ~p0[0].
  - diff[i] = p0[i] ^ G[i−1] for i ≥ 1.
  - borrow = ~G[WIDTH−1].
- Pipeline has DEPTH+1 register stages (S0..SDEPTH); out_valid = valid of SDEPTH.
- Flow control, per stage k:
  - ready_k = ~valid_k | ready_{k+1}, with ready_{DEPTH+1} = out_ready.
  - in_ready = ready_0.
  - A stage loads when ready_k is 1. Its valid becomes the upstream valid; a bubble is loaded when upstream is empty.
- Ordering: strictly in order; no reordering, no drops, no duplication.
- Capacity: DEPTH+1 transactions in flight. A full pipeline with out_ready = 0 drives in_ready to 0.
- Stall: while out_valid & ~out_ready, diff, borrow and ovf stay stable and out_valid stays 1.
- Input side: a and b are sampled only on in_valid & in_ready; any other values are don't-care.
- Reset:
  - Assertion immediately clears all valid bits and all data registers.
  - out_valid = 0, diff = 0, borrow = 0, ovf = 0 while in reset.
  - An in-flight transaction is discarded; no stale result appears after reset release.
  - Input handshakes are ignored while rst = 1.

## Timing
- Latency: a transaction accepted at edge t appears on out_valid/diff in the cycle after edge t+DEPTH, i.e. DEPTH+1 cycles. WIDTH=16 gives 5 cycles.
- Throughput: one result per cycle while out_ready = 1.
- No combinational path from a/b to any output.
- in_ready depends combinationally on out_ready through the valid chain; this is the only combinational ready path.
- Register depth per stage: one AND/OR prefix cell.

## Configuration
- LFA_SUB_OVF_EN defined:
  - Sign bits a[WIDTH−1] and b[WIDTH−1] are carried through the pipeline.
  - ovf = (a_msb ≠ b_msb) & (diff[WIDTH−1] ≠ a_msb).
  - ovf is aligned with diff, reset to 0, and held during stall.
- LFA_SUB_OVF_EN undefined:
  - The ovf port and sign-carry registers do not exist.
  - All other behaviour is identical.

## Test plan
- 0x1234 − 0x0034, out_ready = 1 → after 5 cycles diff = 0x1200, borrow = 0, for one cycle.
- 0x0000 − 0x0001 → diff = 0xFFFF, borrow = 1. 0xABCD − 0xABCD → diff = 0x0000, borrow = 0.
- Streaming: five back-to-back pairs (i, 2i) for i = 1..5 with out_ready = 1 → five consecutive results 0xFFFF..0xFFFB, all borrow = 1, in order, first result 5 cycles after the first accept.
- Backpressure: out_ready = 0 while in_valid is held → exactly 5 accepts, then in_ready = 0 and out_valid/diff stable. After out_ready = 1, all 5 results drain in order and in_ready rises in the same cycle out_ready rises.
- Reset mid-stream: assert rst with 3 transactions in flight → out_valid = 0, diff = 0 immediately. After release, no output until a new transaction has had 5 cycles.
- With LFA_SUB_OVF_EN:
  - 0x8000 − 0x0001 → diff = 0x7FFF, borrow = 0, ovf = 1.
  - 0x7FFF − 0xFFFF → diff = 0x8000, borrow = 1, ovf = 1.
  - 0x0005 − 0x0003 → ovf = 0.
